fwd_hazard_ctrl: RTL

- Parametrised forwarding and hazard controller for the 5-stage pipelined CPU. It supersedes the per-stage forwarding unit.
- Adds register-0 exclusion, regWrite qualification, newest-first priority, load-use stall, taken-branch/jump flush with configurable depth, and halt drain.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB interface registers. It evaluates the instruction in ID against older in-flight instructions and registers the ALU operand selects, so they are valid while that instruction is in EX.

---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_match.sv | 34 +++
 rtl/fwd_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding / hazard controller.
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int unsigned FLUSH_IFID  = 0;
    localparam int unsigned FLUSH_IDEX  = 1;
    localparam int unsigned FLUSH_EXMEM = 2;
    localparam int unsigned FLUSH_W     = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fsm_state_e;

    // Flush vector covering the youngest 'depth' pipeline registers.
    function automatic logic [FLUSH_W-1:0] flushMask(input int unsigned depth);
        logic [FLUSH_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < FLUSH_W; i++) begin
            if (i < depth) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand producer comparator: qualifies a source register against EX and MEM producers.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] opReg,
    input  logic              opUse,
    input  logic [ADDR_W-1:0] exDest,
    input  logic              exRegWrite,
    input  logic [ADDR_W-1:0] memDest,
    input  logic              memRegWrite,
    output logic              exMatch_c,
    output logic              memMatch_c,
    output logic [1:0]        sel_c
);

    logic nonZero;

    // Register 0 is hardwired, so it never creates a dependency.
    assign nonZero    = (opReg != '0);
    assign exMatch_c  = opUse && nonZero && exRegWrite  && (exDest  == opReg);
    assign memMatch_c = opUse && nonZero && memRegWrite && (memDest == opReg);

    always_comb begin
        sel_c = FWD_RF;
        if (exMatch_c) begin
            sel_c = FWD_EXMEM;
        end else if (memMatch_c) begin
            sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall, redirect flush and halt drain control
// for the 5-stage pipeline.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned FLUSH_DEPTH  = 3,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_halt,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_regwrite,
    input  logic                  redirect,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic [2:0]            flush,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_MASK = flushMask(FLUSH_DEPTH);

    fsm_state_e         state;
    fsm_state_e         stateNext;
    logic [DRAIN_W-1:0] drainCnt;
    logic [DRAIN_W-1:0] drainCntNext;
    logic [1:0]         selANext;
    logic [1:0]         selBNext;
    logic               stallEvt;
    logic               flushEvt;

    logic       exMatchA_c;
    logic       exMatchB_c;
    logic       memMatchA_c;
    logic       memMatchB_c;
    logic [1:0] selA_c;
    logic [1:0] selB_c;
    logic       loadUse_c;

    fwd_match #(.ADDR_W(REG_ADDR_W)) u_match_rs (
        .opReg       (id_rs),
        .opUse       (id_use_rs),
        .exDest      (ex_dest),
        .exRegWrite  (ex_regwrite),
        .memDest     (mem_dest),
        .memRegWrite (mem_regwrite),
        .exMatch_c   (exMatchA_c),
        .memMatch_c  (memMatchA_c),
        .sel_c       (selA_c)
    );

    fwd_match #(.ADDR_W(REG_ADDR_W)) u_match_rt (
        .opReg       (id_rt),
        .opUse       (id_use_rt),
        .exDest      (ex_dest),
        .exRegWrite  (ex_regwrite),
        .memDest     (mem_dest),
        .memRegWrite (mem_regwrite),
        .exMatch_c   (exMatchB_c),
        .memMatch_c  (memMatchB_c),
        .sel_c       (selB_c)
    );

    // A load in EX cannot forward yet; MEM-stage matches resolve by forwarding.
    assign loadUse_c = ex_memread && (exMatchA_c || exMatchB_c);

    // Next state, combinational pipeline controls and next operand selects.
    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        flush        = '0;
        selANext     = FWD_RF;
        selBNext     = FWD_RF;
        stallEvt     = 1'b0;
        flushEvt     = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush    = FLUSH_MASK;
                    flushEvt = 1'b1;
                end else begin
                    stall_pc    = loadUse_c;
                    stall_ifid  = loadUse_c;
                    bubble_idex = loadUse_c;
                    if (!loadUse_c) begin
                        selANext = selA_c;
                        selBNext = selB_c;
                    end
                    if (id_halt) begin
                        stateNext    = DRAIN;
                        drainCntNext = DRAIN_LOAD;
                    end else begin
                        stallEvt = loadUse_c;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    // Halt was fetched down the wrong path.
                    flush        = FLUSH_MASK;
                    flushEvt     = 1'b1;
                    stateNext    = RUN;
                    drainCntNext = '0;
                end else begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (drainCnt == '0) begin
                        stateNext = HALTED;
                    end else begin
                        drainCntNext = drainCnt - DRAIN_W'(1);
                    end
                end
            end
            HALTED: begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
            end
            default: begin
                stateNext    = RUN;
                drainCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drainCnt  <= '0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= stateNext;
            drainCnt  <= drainCntNext;
            fwd_a_sel <= selANext;
            fwd_b_sel <= selBNext;
            halted    <= (stateNext == HALTED);
            if (stallEvt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flushEvt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
